// File: rtl/img_loader_if.sv
// Byte-in / pixel-RAM-out signal bundle for the image loader.
// master is the loader side; slave is the UART/core/RAM side.
interface img_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              core_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              start;
  logic              busy;
  logic              overrun;

  modport master (
    input  rx_data, rx_rdy, core_done,
    output wr_en, wr_addr, wr_data, start, busy, overrun
  );

  modport slave (
    output rx_data, rx_rdy, core_done,
    input  wr_en, wr_addr, wr_data, start, busy, overrun
  );
endinterface

// File: rtl/img_loader.sv
// Unpacks received UART bytes LSB-first into a 1-bit pixel RAM, then kicks
// the CNN core once a full frame is written and waits for it to finish.
module img_loader #(
  parameter int unsigned NUM_BYTES = 98,
  parameter int unsigned ADDR_W    = 10
) (
  input logic         clk,
  input logic         rst,
  img_loader_if.master bus
);

  localparam int unsigned BCW = $clog2(NUM_BYTES + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SHIFT     = 2'd1;
  localparam logic [1:0] START     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [7:0]     cur_q, cur_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           overrun_q, overrun_d;
  logic [BCW+2:0] addr_full;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (bus.rx_rdy) begin
          cur_d     = bus.rx_data;
          bit_cnt_d = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == BCW'(NUM_BYTES - 1)) begin
            // Frame complete; anything still pending belongs to no frame.
            state_d     = START;
            hold_full_d = 1'b0;
          end else if (hold_full_q) begin
            cur_d       = hold_q;
            hold_full_d = 1'b0;
            if (bus.rx_rdy) overrun_d = 1'b1;
          end else if (bus.rx_rdy) begin
            // Byte landing on the bit-7 cycle goes straight to the shifter.
            cur_d = bus.rx_data;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.rx_rdy) begin
          if (hold_full_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_d      = bus.rx_data;
            hold_full_d = 1'b1;
          end
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.core_done) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign addr_full   = {byte_cnt_q, bit_cnt_q};
  assign bus.wr_addr = ADDR_W'(addr_full);
  assign bus.wr_en   = (state_q == SHIFT);
  assign bus.wr_data = cur_q[bit_cnt_q];
  assign bus.start   = (state_q == START);
  assign bus.busy    = (state_q != IDLE);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_img_loader.sv
// Scoreboard bench for img_loader: expected pixel writes are queued when bytes
// are driven and popped by a negedge monitor as the DUT writes them.
module tb_img_loader;

  typedef struct {
    logic [9:0] addr;
    logic       d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  img_loader_if #(.ADDR_W(10)) bus ();

  img_loader #(.NUM_BYTES(98), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   run = 0;
  int   max_run = 0;
  int   run_start_cyc = 0;
  int   last_wr_cyc = 0;
  int   last_wr_addr = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;

  // Monitor: checks every write against the scoreboard.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.wr_en === 1'b1) begin
      run = run + 1;
      if (run == 1) run_start_cyc = cyc;
      if (run > max_run) max_run = run;
      last_wr_cyc  = cyc;
      last_wr_addr = int'(bus.wr_addr);
      n_cmp = n_cmp + 1;
      if (q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_write got addr=%0d data=%0b want no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = q.pop_front();
        if (bus.wr_addr !== mon_e.addr || bus.wr_data !== mon_e.d) begin
          n_err = n_err + 1;
          $display("FAIL write got addr=%0d data=%0b want addr=%0d data=%0b",
                   bus.wr_addr, bus.wr_data, mon_e.addr, mon_e.d);
        end
      end
    end else begin
      run = 0;
    end
    if (bus.start === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; drives rx_rdy for exactly one sampling edge.
  task automatic send_byte(input logic [7:0] b, input bit exp_wr, input int base);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    if (exp_wr) begin
      for (int k = 0; k < 8; k++) q.push_back('{addr: 10'(base + k), d: b[k]});
    end
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
  endtask

  task automatic pulse_done();
    bus.core_done = 1'b1;
    @(posedge clk);
    #1;
    bus.core_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    max_run   = 0;
    start_cnt = 0;
  endtask

  task automatic check_drained(input string name);
    n_cmp = n_cmp + 1;
    if (q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL %s_pending got %0d writes outstanding want 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp = n_cmp + 1;
    if ({bus.wr_en, bus.start, bus.busy, bus.overrun, bus.wr_data} !== 5'b0 ||
        bus.wr_addr !== 10'd0) begin
      n_err = n_err + 1;
      $display("FAIL reset_outputs got en/st/busy/ovr/d=%b addr=%0d want 00000 addr=0",
               {bus.wr_en, bus.start, bus.busy, bus.overrun, bus.wr_data}, bus.wr_addr);
    end
    do_reset();
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    send_byte(8'hA5, 1'b1, 0);
    t0 = cyc;
    idle(10);
    check_drained("single");
    n_cmp = n_cmp + 1;
    if (max_run != 8 || run_start_cyc != t0 + 1) begin
      n_err = n_err + 1;
      $display("FAIL single_timing got run=%0d first=%0d want run=8 first=%0d",
               max_run, run_start_cyc, t0 + 1);
    end
    n_cmp = n_cmp + 1;
    if (bus.busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL single_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < 98; i++) begin
      send_byte(8'($urandom), 1'b1, i * 8);
      idle(10);
    end
    check_drained("frame");
    n_cmp = n_cmp + 1;
    if (start_cnt != 1 || start_cyc != last_wr_cyc + 1 || last_wr_addr != 783) begin
      n_err = n_err + 1;
      $display("FAIL frame_start got cnt=%0d at=%0d last_addr=%0d want cnt=1 at=%0d last_addr=783",
               start_cnt, start_cyc, last_wr_addr, last_wr_cyc + 1);
    end
    idle(5);
    n_cmp = n_cmp + 1;
    if (bus.busy !== 1'b1 || start_cnt != 1) begin
      n_err = n_err + 1;
      $display("FAIL frame_wait got busy=%b starts=%0d want busy=1 starts=1",
               bus.busy, start_cnt);
    end
    pulse_done();
    n_cmp = n_cmp + 1;
    if (bus.busy !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL frame_done_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h3B, 1'b1, 0);
    send_byte(8'hD2, 1'b1, 8);
    send_byte(8'hFF, 1'b0, 0);
    idle(20);
    check_drained("b2b");
    n_cmp = n_cmp + 1;
    if (max_run != 16 || bus.overrun !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL b2b_run got run=%0d overrun=%b want run=16 overrun=1",
               max_run, bus.overrun);
    end
    send_byte(8'h81, 1'b1, 16);
    idle(12);
    check_drained("b2b_next");
    n_cmp = n_cmp + 1;
    if (bus.overrun !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL b2b_sticky got overrun=%b want 1", bus.overrun);
    end
  endtask

  task automatic test_wait_done();
    do_reset();
    for (int i = 0; i < 98; i++) begin
      send_byte(8'($urandom), 1'b1, i * 8);
      idle(8);
    end
    idle(3);
    n_cmp = n_cmp + 1;
    if (start_cnt != 1) begin
      n_err = n_err + 1;
      $display("FAIL wd_start got %0d pulses want 1", start_cnt);
    end
    send_byte(8'h3C, 1'b0, 0);
    idle(10);
    check_drained("wd");
    n_cmp = n_cmp + 1;
    if (bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL wd_drop got overrun=%b busy=%b want overrun=0 busy=1",
               bus.overrun, bus.busy);
    end
    pulse_done();
    send_byte(8'h5A, 1'b1, 0);
    idle(10);
    check_drained("wd_next");
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom), 1'b1, i * 8);
      idle(7);
    end
    send_byte(8'hE7, 1'b1, 320);
    idle(2);
    n_cmp = n_cmp + 1;
    if (max_run < 320 || bus.wr_en !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL rst_seamless got run=%0d wr_en=%b want run>=320 wr_en=1",
               max_run, bus.wr_en);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp = n_cmp + 1;
    if ({bus.wr_en, bus.start, bus.busy, bus.overrun, bus.wr_data} !== 5'b0 ||
        bus.wr_addr !== 10'd0) begin
      n_err = n_err + 1;
      $display("FAIL rst_async got en/st/busy/ovr/d=%b addr=%0d want 00000 addr=0",
               {bus.wr_en, bus.start, bus.busy, bus.overrun, bus.wr_data}, bus.wr_addr);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_cnt = 0;
    send_byte(8'hC3, 1'b1, 0);
    idle(10);
    check_drained("rst_next");
  endtask

  task automatic test_core_done_ignore();
    do_reset();
    pulse_done();
    n_cmp = n_cmp + 1;
    if (bus.busy !== 1'b0 || start_cnt != 0) begin
      n_err = n_err + 1;
      $display("FAIL cd_idle got busy=%b starts=%0d want busy=0 starts=0",
               bus.busy, start_cnt);
    end
    send_byte(8'h96, 1'b1, 0);
    idle(2);
    pulse_done();
    n_cmp = n_cmp + 1;
    if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL cd_shift got busy=%b wr_en=%b want busy=1 wr_en=1",
               bus.busy, bus.wr_en);
    end
    idle(8);
    send_byte(8'h69, 1'b1, 8);
    idle(10);
    check_drained("cd");
    n_cmp = n_cmp + 1;
    if (start_cnt != 0) begin
      n_err = n_err + 1;
      $display("FAIL cd_start got %0d pulses want 0", start_cnt);
    end
  endtask

  initial begin
    bus.rx_data   = 8'd0;
    bus.rx_rdy    = 1'b0;
    bus.core_done = 1'b0;
    test_reset();
    test_single();
    test_full_frame();
    test_back_to_back();
    test_wait_done();
    test_rst_mid();
    test_core_done_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got no completion want finish within 1ms");
    $fatal(1, "timeout");
  end

endmodule
